// File: rtl/interrupt_ir_control.sv
// Instruction register load and interrupt sequencing for the 6502 core.
// Chooses between the fetched opcode and a forced BRK, and supplies the vector, B flag and write-suppress.
module interrupt_ir_control #(
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_sync,
  input  logic [2:0]  i_tcu,
  input  logic        i_rdy,
  input  logic [7:0]  i_data,
  input  logic        i_nmi_n,
  input  logic        i_irq_n,
  input  logic        i_flag_i,
  output logic [7:0]  o_ir,
  output logic        o_int_active,
  output logic [1:0]  o_int_source,
  output logic [15:0] o_vector,
  output logic        o_b_flag,
  output logic        o_write_suppress
);

  localparam logic [1:0] SRC_SW  = 2'd0;
  localparam logic [1:0] SRC_IRQ = 2'd1;
  localparam logic [1:0] SRC_NMI = 2'd2;
  localparam logic [1:0] SRC_RST = 2'd3;

  typedef struct packed {
    logic [7:0]  ir;
    logic        act;
    logic [1:0]  src;
    logic [15:0] vec;
    logic        b;
    logic        ws;
  } ir_rsp_t;

  localparam ir_rsp_t RST_RSP = '{ir: 8'h00, act: 1'b1, src: SRC_RST, vec: RESET_VECTOR, b: 1'b0, ws: 1'b1};
  localparam ir_rsp_t NMI_RSP = '{ir: 8'h00, act: 1'b1, src: SRC_NMI, vec: NMI_VECTOR,   b: 1'b0, ws: 1'b0};
  localparam ir_rsp_t IRQ_RSP = '{ir: 8'h00, act: 1'b1, src: SRC_IRQ, vec: IRQ_VECTOR,   b: 1'b0, ws: 1'b0};

  logic    r_reset_pending, r_nmi_pending, r_nmi_prev, r_irq_req;
  ir_rsp_t r_rsp, rsp_nxt;
  logic    load, nmi_edge, unused_tcu;

  assign load       = i_sync & i_rdy;
  assign nmi_edge   = r_nmi_prev & ~i_nmi_n;
  // T-state only matters for when o_int_active drops, which is already tied to the load edge.
  assign unused_tcu = ^i_tcu;

  always_comb begin
    rsp_nxt = '{ir: i_data, act: 1'b0, src: SRC_SW, vec: IRQ_VECTOR, b: 1'b1, ws: 1'b0};
    if (r_reset_pending)    rsp_nxt = RST_RSP;
    else if (r_nmi_pending) rsp_nxt = NMI_RSP;
    else if (r_irq_req)     rsp_nxt = IRQ_RSP;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rsp           <= RST_RSP;
      r_reset_pending <= 1'b1;
      r_nmi_pending   <= 1'b0;
      r_nmi_prev      <= 1'b1;
      r_irq_req       <= 1'b0;
    end else begin
      r_nmi_prev <= i_nmi_n;
      r_irq_req  <= ~i_irq_n & ~i_flag_i;
      if (load) begin
        r_rsp           <= rsp_nxt;
        r_reset_pending <= 1'b0;
      end
      // A fresh edge beats the clear, so an NMI arriving while one is taken is not lost.
      if (nmi_edge)
        r_nmi_pending <= 1'b1;
      else if (load && !r_reset_pending)
        r_nmi_pending <= 1'b0;
    end
  end

  assign o_ir             = r_rsp.ir;
  assign o_int_active     = r_rsp.act;
  assign o_int_source     = r_rsp.src;
  assign o_vector         = r_rsp.vec;
  assign o_b_flag         = r_rsp.b;
  assign o_write_suppress = r_rsp.ws;

endmodule

// File: doc/interrupt_ir_control.md
Name: interrupt_ir_control

Overview:
- Consumes the opcode-fetch indication (sync) and T-state from the timing control unit of the cpu6502.
- Loads the instruction register from the data bus on each opcode fetch, or forces a BRK (0x00) when reset, NMI or IRQ is pending.
- Tracks interrupt sources and supplies the decoder with the vector address, the B-flag value and the write-suppress flag for the reset sequence.

Parameters:
- NMI_VECTOR, 16'hFFFA, NMI vector address
- RESET_VECTOR, 16'hFFFC, reset vector address
- IRQ_VECTOR, 16'hFFFE, IRQ/BRK vector address

Ports:
- i_clk  input  1  system clock; all state updates on posedge
- i_reset_n  input  1  asynchronous active-low reset
- i_sync  input  1  opcode-fetch cycle indicator from the timing control unit
- i_tcu  input  3  current T-state; informational, used only for the o_int_active clear rule
- i_rdy  input  1  bus ready; 0 stalls the instruction register load
- i_data  input  8  data bus (opcode byte during a sync cycle)
- i_nmi_n  input  1  NMI line, active low, edge-sensitive
- i_irq_n  input  1  IRQ line, active low, level-sensitive
- i_flag_i  input  1  interrupt-disable flag from the P register
- o_ir  output  8  instruction register
- o_int_active  output  1  current instruction is a hardware-forced BRK
- o_int_source  output  2  0=software BRK/normal, 1=IRQ, 2=NMI, 3=RESET
- o_vector  output  16  vector address for the current BRK sequence
- o_b_flag  output  1  B value to push: 1 = software BRK, 0 = hardware interrupt
- o_write_suppress  output  1  1 = convert stack writes to reads (reset sequence)

Behaviour:
- Reset (i_reset_n=0, asynchronous) sets:
  - o_ir=0x00, o_int_active=1, o_int_source=3, o_vector=RESET_VECTOR, o_b_flag=0, o_write_suppress=1
  - r_reset_pending=1, r_nmi_pending=0, r_nmi_prev=1, r_irq_req=0
- Every clock:
  - r_nmi_prev <= i_nmi_n.
  - NMI edge: r_nmi_prev=1 and i_nmi_n=0 sets r_nmi_pending. A line held low does not retrigger; it must return high for at least 1 clock first.
  - r_irq_req <= (!i_irq_n && !i_flag_i).
- Load cycle = posedge where i_sync=1 and i_rdy=1. Decisions use the registered pending values from before that edge, so a request must be registered at least 1 clock before the load edge.
- Load priority: RESET > NMI > IRQ > normal.
  - RESET: o_ir=0x00, o_int_source=3, o_int_active=1, o_vector=RESET_VECTOR, o_b_flag=0, o_write_suppress=1; clear r_reset_pending.
  - NMI: o_ir=0x00, o_int_source=2, o_int_active=1, o_vector=NMI_VECTOR, o_b_flag=0, o_write_suppress=0; clear r_nmi_pending.
  - IRQ: o_ir=0x00, o_int_source=1, o_int_active=1, o_vector=IRQ_VECTOR, o_b_flag=0, o_write_suppress=0. IRQ has no pending latch: if the line is released or I is set before the load, the IRQ is not taken.
  - Normal: o_ir=i_data, o_int_source=0, o_int_active=0, o_vector=IRQ_VECTOR, o_b_flag=1, o_write_suppress=0.
- Simultaneous set and clear of r_nmi_pending on the same edge (new edge arrives while NMI is taken): set wins, so a second NMI is taken at the next load.
- An NMI edge while a RESET or IRQ sequence is being taken stays pending and is taken at the next load cycle.
- i_sync=1 with i_rdy=0: no load; o_ir, all outputs and all pending state hold. The NMI edge detector keeps sampling.
- All outputs change only on reset or on a load edge (o_int_active excepted, see next rule); no output is combinational.
- o_int_active clears at the next load edge that selects normal; i_tcu has no effect on it otherwise.
- Asserting reset mid-instruction immediately forces the reset values above, discarding any pending NMI.

Test Plan:
- Reset held 3 clocks, then released; sync+rdy pulse with i_data=0xA9 → after reset and after the first load: o_ir=0x00, o_int_source=3, o_vector=FFFC, o_write_suppress=1. Next load with i_data=0xA9 → o_ir=0xA9, o_int_source=0, o_b_flag=1, o_write_suppress=0.
- i_nmi_n falls 2 clocks before a load with i_data=0xEA → o_ir=0x00, o_int_source=2, o_vector=FFFA, o_b_flag=0. i_nmi_n held low through the following load → o_ir=0xEA (no retrigger).
- i_irq_n=0 with i_flag_i=1 at a load → o_ir=i_data (0x18). Same with i_flag_i=0 → o_ir=0x00, o_int_source=1, o_vector=FFFE.
- NMI edge and IRQ both pending at the same load → NMI taken (source 2). IRQ still asserted at the next load → source 1.
- i_sync=1, i_rdy=0 for 3 clocks with i_data changing, then i_rdy=1 with i_data=0x4C → o_ir holds its old value during the stall, then becomes 0x4C.
- New NMI edge on the same edge an NMI is taken → the next load is also NMI (source 2, o_ir=0x00).
